// File: rtl/if_fetch_controller.sv
// Instruction-fetch sequencer for a multi-cycle instruction memory.
// Owns the PC, issues word-aligned req/ready fetches, absorbs hazard
// freezes through a one-entry skid buffer, squashes in-flight fetches on
// branch redirects, and presents one registered slot to the IF/ID register.
module if_fetch_controller #(
   parameter logic [31:0] RESET_PC    = 32'd0,
   parameter int          STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   freeze,
   input  logic                   branch_taken,
   input  logic [31:0]            branch_address,
   output logic                   imem_req,
   output logic [31:0]            imem_addr,
   input  logic                   imem_ready,
   input  logic [31:0]            imem_rdata,
   output logic                   if_valid,
   output logic [31:0]            if_pc,
   output logic [31:0]            if_instruction,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      S_FETCH,
      S_HOLD,
      S_SQUASH
   } state_t;

   localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;
   localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

   state_t                 r_state;
   logic [31:0]            r_pc;
   logic [31:0]            r_squashAddr;
   logic [31:0]            r_skidPc;
   logic [31:0]            r_skidInstr;
   logic                   r_valid;
   logic [31:0]            r_ifPc;
   logic [31:0]            r_instr;
   logic [STALL_CNT_W-1:0] r_stallCnt;

   logic        w_consume;
   logic        w_slotFree;
   logic [31:0] w_pcNext;
   logic [31:0] w_target;
   logic        w_stallTick;

   // The slot drains whenever it is occupied and IF/ID is not frozen;
   // the low two bits of a redirect target are dropped to keep fetches aligned.
   assign w_consume   = r_valid & ~freeze;
   assign w_slotFree  = ~r_valid | w_consume;
   assign w_pcNext    = r_pc + 32'd4;
   assign w_target    = branch_address & 32'hFFFF_FFFC;

   // A request is outstanding in FETCH and SQUASH, but never while reset is held.
   assign imem_req    = (r_state != S_HOLD) & ~rst;
   assign imem_addr   = (r_state == S_SQUASH) ? r_squashAddr : r_pc;
   assign w_stallTick = (imem_req & ~imem_ready) | (r_state == S_HOLD);

   assign if_valid       = r_valid;
   assign if_pc          = r_ifPc;
   assign if_instruction = r_instr;
   assign stall_cnt      = r_stallCnt;

   // Main FSM: PC, slot, skid buffer and squash bookkeeping; redirects win over everything else.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_FETCH;
         r_pc         <= RESET_PC;
         r_squashAddr <= 32'd0;
         r_skidPc     <= 32'd0;
         r_skidInstr  <= 32'd0;
         r_valid      <= 1'b0;
         r_ifPc       <= 32'd0;
         r_instr      <= 32'd0;
      end else if (branch_taken) begin
         r_valid <= 1'b0;
         r_pc    <= w_target;
         case (r_state)
            S_FETCH: begin
               if (!imem_ready) begin
                  r_squashAddr <= r_pc;
                  r_state      <= S_SQUASH;
               end
            end
            S_HOLD:   r_state <= S_FETCH;
            S_SQUASH: r_state <= S_SQUASH;
            default:  r_state <= S_FETCH;
         endcase
      end else begin
         if (w_consume) begin
            r_valid <= 1'b0;
         end
         case (r_state)
            S_FETCH: begin
               if (imem_ready) begin
                  r_pc <= w_pcNext;
                  if (w_slotFree) begin
                     r_valid <= 1'b1;
                     r_ifPc  <= w_pcNext;
                     r_instr <= imem_rdata;
                  end else begin
                     r_skidPc    <= w_pcNext;
                     r_skidInstr <= imem_rdata;
                     r_state     <= S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (w_consume) begin
                  r_valid <= 1'b1;
                  r_ifPc  <= r_skidPc;
                  r_instr <= r_skidInstr;
                  r_state <= S_FETCH;
               end
            end
            S_SQUASH: begin
               if (imem_ready) begin
                  r_state <= S_FETCH;
               end
            end
            default: r_state <= S_FETCH;
         endcase
      end
   end

   // Saturating count of cycles lost waiting on memory or parked in the skid state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stallCnt <= '0;
      end else if (w_stallTick && (r_stallCnt != STALL_MAX)) begin
         r_stallCnt <= r_stallCnt + STALL_ONE;
      end
   end

endmodule

// File: tb/tb_if_fetch_controller.sv
// Self-checking bench for if_fetch_controller: two instances (default reset
// PC, and a top-of-memory reset PC with a narrow stall counter) share the
// same stimulus and are each compared against a queue-style reference model.
module tb_if_fetch_controller;

   localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        freeze;
   logic        branchTaken;
   logic [31:0] branchAddress;
   logic        imemReady;
   logic [31:0] imemRdata;

   logic        reqA, validA;
   logic [31:0] addrA, pcA, insA;
   logic [15:0] stallA;
   logic        reqB, validB;
   logic [31:0] addrB, pcB, insB;
   logic [2:0]  stallB;

   if_fetch_controller dut (
      .clk(clk), .rst(rst), .freeze(freeze),
      .branch_taken(branchTaken), .branch_address(branchAddress),
      .imem_req(reqA), .imem_addr(addrA),
      .imem_ready(imemReady), .imem_rdata(imemRdata),
      .if_valid(validA), .if_pc(pcA), .if_instruction(insA),
      .stall_cnt(stallA)
   );

   if_fetch_controller #(.RESET_PC(WRAP_PC), .STALL_CNT_W(3)) dutWrap (
      .clk(clk), .rst(rst), .freeze(freeze),
      .branch_taken(branchTaken), .branch_address(branchAddress),
      .imem_req(reqB), .imem_addr(addrB),
      .imem_ready(imemReady), .imem_rdata(imemRdata),
      .if_valid(validB), .if_pc(pcB), .if_instruction(insB),
      .stall_cnt(stallB)
   );

   // Reference model: buffered instructions as a two-deep FIFO (slot, then skid),
   // the next fetch PC, and an optional address being fetched only to be thrown away.
   logic [31:0] resetPc [2];
   int          satMax  [2];
   logic [31:0] mPc     [2];
   logic [31:0] mSqAddr [2];
   bit          mSquash [2];
   int          mCnt    [2];
   int          mStall  [2];
   logic [31:0] ePc     [2][2];
   logic [31:0] eIns    [2][2];

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s at %0t: observed=%h expected=%h", tag, $time, obs, exp);
      end
   endtask

   task automatic popSlot(input int m);
      ePc[m][0]  = ePc[m][1];
      eIns[m][0] = eIns[m][1];
      mCnt[m]--;
   endtask

   task automatic pushSlot(input int m, input logic [31:0] pc, input logic [31:0] ins);
      ePc[m][mCnt[m]]  = pc;
      eIns[m][mCnt[m]] = ins;
      mCnt[m]++;
   endtask

   // Advance one model by one clock edge using the inputs currently driven.
   task automatic stepModel(input int m);
      bit req, hold, consume;
      if (rst) begin
         mCnt[m]    = 0;
         mPc[m]     = resetPc[m];
         mSquash[m] = 0;
         mStall[m]  = 0;
         return;
      end
      hold    = !mSquash[m] && (mCnt[m] == 2);
      req     = mSquash[m] || (mCnt[m] < 2);
      consume = (mCnt[m] > 0) && !freeze;
      if (((req && !imemReady) || hold) && (mStall[m] < satMax[m])) mStall[m]++;
      if (branchTaken) begin
         if (!mSquash[m] && req && !imemReady) begin
            mSquash[m] = 1;
            mSqAddr[m] = mPc[m];
         end
         mCnt[m] = 0;
         mPc[m]  = branchAddress & 32'hFFFF_FFFC;
      end else begin
         if (consume) popSlot(m);
         if (mSquash[m]) begin
            if (imemReady) mSquash[m] = 0;
         end else if (!hold && imemReady) begin
            pushSlot(m, mPc[m] + 32'd4, imemRdata);
            mPc[m] = mPc[m] + 32'd4;
         end
      end
   endtask

   task automatic checkOne(input int m, input string name, input logic req, input logic [31:0] addr,
                           input logic valid, input logic [31:0] pc, input logic [31:0] ins,
                           input logic [31:0] stall);
      logic expReq, expValid;
      expReq   = !rst && (mSquash[m] || (mCnt[m] < 2));
      expValid = (mCnt[m] > 0);
      checkVal({name, ".imem_req"}, {31'd0, req}, {31'd0, expReq});
      checkVal({name, ".imem_addr"}, addr, mSquash[m] ? mSqAddr[m] : mPc[m]);
      checkVal({name, ".if_valid"}, {31'd0, valid}, {31'd0, expValid});
      if (expValid) begin
         checkVal({name, ".if_pc"}, pc, ePc[m][0]);
         checkVal({name, ".if_instruction"}, ins, eIns[m][0]);
      end
      checkVal({name, ".stall_cnt"}, stall, 32'(mStall[m]));
   endtask

   task automatic checkOutput();
      checkOne(0, "dut", reqA, addrA, validA, pcA, insA, {16'd0, stallA});
      checkOne(1, "dutWrap", reqB, addrB, validB, pcB, insB, {29'd0, stallB});
   endtask

   // One cycle: drive inputs, let combinational outputs settle, compare, then clock both DUTs and models.
   task automatic applyStimulus(input logic r, input logic f, input logic b,
                                input logic [31:0] ba, input logic rdy);
      rst           = r;
      freeze        = f;
      branchTaken   = b;
      branchAddress = ba;
      imemReady     = rdy;
      imemRdata     = $urandom;
      #1;
      checkOutput();
      @(posedge clk);
      stepModel(0);
      stepModel(1);
      #1;
   endtask

   initial begin
      logic [31:0] ba;
      int pFreeze, pReady;
      resetPc[0] = 32'd0;
      resetPc[1] = WRAP_PC;
      satMax[0]  = 65535;
      satMax[1]  = 7;
      for (int m = 0; m < 2; m++) begin
         mPc[m] = resetPc[m]; mSqAddr[m] = 0; mSquash[m] = 0; mCnt[m] = 0; mStall[m] = 0;
      end
      rst = 1'b1; freeze = 1'b0; branchTaken = 1'b0; branchAddress = 32'd0;
      imemReady = 1'b0; imemRdata = 32'd0;
      @(posedge clk);
      stepModel(0);
      stepModel(1);
      #1;

      // Reset held a second cycle: request must stay low.
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
      rst = 1'b0;
      #1;
      checkVal("reset.if_pc", pcA, 32'd0);
      checkVal("reset.if_instruction", insA, 32'd0);
      checkVal("reset.imem_addr", addrA, 32'd0);
      checkVal("resetWrap.imem_addr", addrB, WRAP_PC);

      // Zero-wait streaming fetches with no freeze.
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      // Freeze held while memory keeps answering: fills the skid and parks.
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
      // Redirect while frozen and parked: target 0x93 aligns to 0x90.
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h93, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      // Two-wait-state fetches.
      for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, (i % 3) == 2);
      // Redirect to 0x70 while a slow fetch is pending: squash then resume.
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h70, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, i == 2);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      // Reset in the middle of a pending request.
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

      // Randomized traffic in blocks with varying freeze/ready pressure.
      for (int blk = 0; blk < 30; blk++) begin
         pFreeze = $urandom_range(0, 80);
         pReady  = $urandom_range(15, 100);
         for (int i = 0; i < 100; i++) begin
            ba = $urandom;
            if ($urandom_range(0, 3) == 0) ba = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            applyStimulus($urandom_range(0, 59) == 0,
                          $urandom_range(0, 99) < pFreeze,
                          $urandom_range(0, 11) == 0,
                          ba,
                          $urandom_range(0, 99) < pReady);
         end
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
